// File: rtl/msk_rnd_source.sv
// Fresh-randomness source for masked gadgets: a bank of 32-bit Galois LFSR lanes.
// The lanes are seeded over a valid/ready port and warmed up before rnd is released.
module msk_rnd_source #(
  parameter int          d      = 2,
  parameter int          RND_W  = d*(d-1)/2,
  parameter int          WARMUP = 64,
  parameter logic [31:0] TAPS   = 32'hA300_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      seed_in,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic             reseed,
  input  logic             rnd_ready,
  output logic             rnd_valid,
  output logic [RND_W-1:0] rnd,
  output logic [1:0]       fsm_state
);

  localparam int K  = (RND_W + 31) / 32;
  localparam int LW = (K > 1) ? $clog2(K) : 1;
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WARM = 2'd2, RUN = 2'd3} state_t;

  state_t          state;
  logic [32*K-1:0] lane_q;
  logic [LW-1:0]   load_cnt;
  logic [WW-1:0]   warm_cnt;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? TAPS : 32'h0);
  endfunction

  // Handshakes: a seed word moves on a rising edge where seed_valid && seed_ready;
  // an rnd word is consumed on a rising edge where rnd_valid && rnd_ready.
  // seed_ready and rnd_valid are registered and never depend on same-cycle inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lane_q     <= '0;
      load_cnt   <= '0;
      warm_cnt   <= '0;
      seed_ready <= 1'b0;
      rnd_valid  <= 1'b0;
    end else if (reseed) begin
      // Lanes keep their contents until overwritten by the new seeds.
      state      <= LOAD;
      load_cnt   <= '0;
      warm_cnt   <= '0;
      seed_ready <= 1'b1;
      rnd_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          seed_ready <= 1'b1;
          rnd_valid  <= 1'b0;
          if (seed_valid && seed_ready) begin
            for (int k = 0; k < K; k++) begin
              if (load_cnt == LW'(k)) begin
                lane_q[32*k +: 32] <= (seed_in == 32'h0) ? 32'h0000_0001 : seed_in;
              end
            end
            if (load_cnt == LW'(K-1)) begin
              load_cnt   <= '0;
              seed_ready <= 1'b0;
              if (WARMUP > 0) begin
                state <= WARM;
              end else begin
                state     <= RUN;
                rnd_valid <= 1'b1;
              end
            end else begin
              load_cnt <= load_cnt + LW'(1);
              state    <= LOAD;
            end
          end
        end
        WARM: begin
          seed_ready <= 1'b0;
          for (int k = 0; k < K; k++) begin
            lane_q[32*k +: 32] <= lfsr_step(lane_q[32*k +: 32]);
          end
          if (warm_cnt == WW'(WARMUP-1)) begin
            warm_cnt  <= '0;
            state     <= RUN;
            rnd_valid <= 1'b1;
          end else begin
            warm_cnt <= warm_cnt + WW'(1);
          end
        end
        default: begin
          seed_ready <= 1'b0;
          rnd_valid  <= 1'b1;
          if (rnd_ready) begin
            for (int k = 0; k < K; k++) begin
              lane_q[32*k +: 32] <= lfsr_step(lane_q[32*k +: 32]);
            end
          end
        end
      endcase
    end
  end

  assign rnd       = lane_q[RND_W-1:0];
  assign fsm_state = state;

endmodule
